// File: rtl/imem_dmem_arbiter_pkg.sv
// Shared types and helpers for the fetch/data memory arbiter.
// Holds the FSM state and owner encodings plus the starve-counter width helper.
package imem_dmem_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_REQ  = 2'd1,
        ARB_RESP = 2'd2
    } arb_state_e;

    typedef enum logic {
        ARB_FETCH = 1'b0,
        ARB_DATA  = 1'b1
    } arb_owner_e;

    localparam int unsigned ARB_STARVE_LIMIT_DEF = 4;
    localparam int unsigned ARB_XLEN             = 32;

    // Counter must hold the value STARVE_LIMIT itself.
    function automatic int unsigned starve_cnt_width(input int unsigned limit);
        return (limit < 1) ? 1 : $clog2(limit + 1);
    endfunction

endpackage

// File: rtl/imem_dmem_arbiter_prio_sel.sv
// Combinational winner pick between fetch and data, with the starve counter update.
// Data wins contention until fetch has waited STARVE_LIMIT data grants.
module arb_prio_sel
    import imem_dmem_arbiter_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = ARB_STARVE_LIMIT_DEF,
    parameter int unsigned CW           = starve_cnt_width(ARB_STARVE_LIMIT_DEF)
) (
    input  logic          i_ifetch_req,
    input  logic          i_data_req,
    input  logic [CW-1:0] i_starve_cnt,
    output logic          o_grant_fetch,
    output logic          o_grant_data,
    output logic [CW-1:0] o_starve_cnt
);

    logic w_limit_hit;

    assign w_limit_hit   = (i_starve_cnt == CW'(STARVE_LIMIT));
    assign o_grant_data  = i_data_req && !(i_ifetch_req && w_limit_hit);
    assign o_grant_fetch = i_ifetch_req && !o_grant_data;

    always_comb begin
        o_starve_cnt = i_starve_cnt;
        if (o_grant_fetch) begin
            o_starve_cnt = '0;
        end else if (o_grant_data && i_ifetch_req && !w_limit_hit) begin
            o_starve_cnt = i_starve_cnt + CW'(1);
        end
    end

endmodule

// File: rtl/imem_dmem_arbiter.sv
// Shares one single-port memory between instruction fetch and the MEM stage.
// One transaction in flight; re-arbitrates in the response cycle for back-to-back use.
module imem_dmem_arbiter
    import imem_dmem_arbiter_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = ARB_STARVE_LIMIT_DEF
) (
    input  logic        clk_i,
    input  logic        rstn_i,
    input  logic        ifetch_req_i,
    input  logic [31:0] ifetch_addr_i,
    input  logic        ifetch_kill_i,
    output logic        ifetch_gnt_o,
    output logic        ifetch_rvalid_o,
    output logic [31:0] ifetch_rdata_o,
    input  logic        data_req_i,
    input  logic        data_we_i,
    input  logic [31:0] data_addr_i,
    input  logic [3:0]  data_wsel_byte_i,
    input  logic [31:0] data_wdata_i,
    output logic        data_gnt_o,
    output logic        data_rvalid_o,
    output logic [31:0] data_rdata_o,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [3:0]  mem_wsel_byte_o,
    output logic [31:0] mem_wdata_o,
    input  logic        mem_gnt_i,
    input  logic        mem_rvalid_i,
    input  logic [31:0] mem_rdata_i
);

    localparam int unsigned CW = starve_cnt_width(STARVE_LIMIT);

    arb_state_e    r_state;
    arb_state_e    w_state_next;
    arb_owner_e    r_owner;
    logic [CW-1:0] r_starve_cnt;
    logic [CW-1:0] w_starve_cnt_next;
    logic          r_kill;
    logic          r_is_write;

    logic          r_mem_req;
    logic          r_mem_we;
    logic [31:0]   r_mem_addr;
    logic [3:0]    r_mem_wsel;
    logic [31:0]   r_mem_wdata;

    logic          r_ifetch_rvalid;
    logic [31:0]   r_ifetch_rdata;
    logic          r_data_rvalid;
    logic [31:0]   r_data_rdata;

    logic          w_sel_fetch;
    logic          w_sel_data;
    logic          w_resp_done;
    logic          w_arb_en;
    logic          w_gnt_fetch;
    logic          w_gnt_data;
    logic          w_grant_any;
    logic          w_kill_now;
    logic          w_kill_eff;

    arb_prio_sel #(
        .STARVE_LIMIT (STARVE_LIMIT),
        .CW           (CW)
    ) u_prio_sel (
        .i_ifetch_req  (ifetch_req_i),
        .i_data_req    (data_req_i),
        .i_starve_cnt  (r_starve_cnt),
        .o_grant_fetch (w_sel_fetch),
        .o_grant_data  (w_sel_data),
        .o_starve_cnt  (w_starve_cnt_next)
    );

    assign w_resp_done = (r_state == ARB_RESP) && mem_rvalid_i;
    assign w_arb_en    = (r_state == ARB_IDLE) || w_resp_done;
    assign w_grant_any = w_gnt_fetch || w_gnt_data;
    assign w_kill_now  = ifetch_kill_i && (r_owner == ARB_FETCH) &&
                         ((r_state == ARB_REQ) || (r_state == ARB_RESP));
    assign w_kill_eff  = r_kill || w_kill_now;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_state <= ARB_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ARB_IDLE: if (w_grant_any) w_state_next = ARB_REQ;
            ARB_REQ:  if (mem_gnt_i) w_state_next = ARB_RESP;
            ARB_RESP: if (mem_rvalid_i) w_state_next = w_grant_any ? ARB_REQ : ARB_IDLE;
            default:  w_state_next = ARB_IDLE;
        endcase
    end

    // Grants are combinational; held low while reset is asserted.
    always_comb begin
        w_gnt_fetch = rstn_i && w_arb_en && w_sel_fetch;
        w_gnt_data  = rstn_i && w_arb_en && w_sel_data;
    end

    assign ifetch_gnt_o = w_gnt_fetch;
    assign data_gnt_o   = w_gnt_data;

    // mem_* fields are only non-zero while the request is outstanding.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wsel  <= '0;
            r_mem_wdata <= '0;
            r_is_write  <= 1'b0;
            r_owner     <= ARB_FETCH;
        end else if (w_gnt_data) begin
            r_mem_req   <= 1'b1;
            r_mem_we    <= data_we_i;
            r_mem_addr  <= data_addr_i;
            r_mem_wsel  <= data_we_i ? data_wsel_byte_i : 4'b0000;
            r_mem_wdata <= data_we_i ? data_wdata_i : 32'h0;
            r_is_write  <= data_we_i;
            r_owner     <= ARB_DATA;
        end else if (w_gnt_fetch) begin
            r_mem_req   <= 1'b1;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= ifetch_addr_i;
            r_mem_wsel  <= 4'b0000;
            r_mem_wdata <= 32'h0;
            r_is_write  <= 1'b0;
            r_owner     <= ARB_FETCH;
        end else if ((r_state == ARB_REQ) && mem_gnt_i) begin
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wsel  <= '0;
            r_mem_wdata <= '0;
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_starve_cnt <= '0;
            r_kill       <= 1'b0;
        end else begin
            if (w_grant_any) begin
                r_starve_cnt <= w_starve_cnt_next;
            end
            // A kill alongside a fetch grant targets the newly granted fetch.
            if (w_gnt_fetch && ifetch_kill_i) begin
                r_kill <= 1'b1;
            end else if (w_resp_done) begin
                r_kill <= 1'b0;
            end else if (w_kill_now) begin
                r_kill <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_ifetch_rvalid <= 1'b0;
            r_ifetch_rdata  <= '0;
            r_data_rvalid   <= 1'b0;
            r_data_rdata    <= '0;
        end else begin
            r_ifetch_rvalid <= w_resp_done && (r_owner == ARB_FETCH) && !w_kill_eff;
            r_ifetch_rdata  <= (w_resp_done && (r_owner == ARB_FETCH) && !w_kill_eff) ?
                               mem_rdata_i : 32'h0;
            r_data_rvalid   <= w_resp_done && (r_owner == ARB_DATA);
            r_data_rdata    <= (w_resp_done && (r_owner == ARB_DATA) && !r_is_write) ?
                               mem_rdata_i : 32'h0;
        end
    end

    assign mem_req_o       = r_mem_req;
    assign mem_we_o        = r_mem_we;
    assign mem_addr_o      = r_mem_addr;
    assign mem_wsel_byte_o = r_mem_wsel;
    assign mem_wdata_o     = r_mem_wdata;
    assign ifetch_rvalid_o = r_ifetch_rvalid;
    assign ifetch_rdata_o  = r_ifetch_rdata;
    assign data_rvalid_o   = r_data_rvalid;
    assign data_rdata_o    = r_data_rdata;

`ifndef SYNTHESIS
    a_rvalid_only_in_resp: assert property (@(posedge clk_i) disable iff (!rstn_i)
        mem_rvalid_i |-> (r_state == ARB_RESP));
`endif

endmodule
